alu_issue_stage: RTL and testbench

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage.sv | 139 +++++++++++++
 tb/tb_alu_issue_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: valid/ready issue register between decode and a MIPS
// WIDTH-slice ALU. It decodes ALUOp/funct into slice controls
// (binv, cin, sel1, sel0) and counts output handshakes.
// Optional macro ALU_ISSUE_SKID_EN adds a one-entry skid buffer so that
// in_ready is registered. Without the macro, in_ready is combinational.
module alu_issue_stage #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_aluop,
  input  logic [5:0]       in_funct,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_binv,
  output logic             out_cin,
  output logic             out_sel1,
  output logic             out_sel0,
  output logic             out_illegal,
  output logic [15:0]      issue_cnt
);

  // Op word layout: {a, b, binv, sel[1:0], illegal}
  localparam int unsigned OPW = 2 * WIDTH + 4;

  logic           dec_binv;
  logic [1:0]     dec_sel;
  logic           dec_illegal;
  logic [OPW-1:0] dec_op;
  logic [OPW-1:0] out_q;
  logic           in_hs;
  logic           out_hs;

  // Decode ALUOp/funct into slice controls; sel: 00=AND 01=OR 10=SUM 11=LESS
  always_comb begin
    dec_binv    = 1'b0;
    dec_sel     = 2'b10;
    dec_illegal = 1'b0;
    case (in_aluop)
      2'b01: dec_binv = 1'b1;
      2'b11: dec_sel  = 2'b01;
      2'b10: begin
        case (in_funct)
          6'b100000: dec_sel = 2'b10;
          6'b100010: dec_binv = 1'b1;
          6'b100100: dec_sel = 2'b00;
          6'b100101: dec_sel = 2'b01;
          6'b101010: begin
            dec_binv = 1'b1;
            dec_sel  = 2'b11;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_sel = 2'b10;
    endcase
    dec_op = {in_a, in_b, dec_binv, dec_sel, dec_illegal};
  end

  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  // Unpack the output register; cin mirrors binv to form two's complement
  assign out_a       = out_q[OPW-1 -: WIDTH];
  assign out_b       = out_q[4 +: WIDTH];
  assign out_binv    = out_q[3];
  assign out_cin     = out_q[3];
  assign out_sel1    = out_q[2];
  assign out_sel0    = out_q[1];
  assign out_illegal = out_q[0];

`ifdef ALU_ISSUE_SKID_EN
  logic           skid_full;
  logic [OPW-1:0] skid_q;
  logic           ready_q;

  // ready_q tracks !skid_full; reset still blocks a handshake in its cycle
  assign in_ready = ready_q && !reset;

  // Output register plus skid entry; skid drains into the output first
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      skid_full <= 1'b0;
      skid_q    <= '0;
      ready_q   <= 1'b1;
      issue_cnt <= 16'd0;
    end else begin
      if (out_hs) issue_cnt <= issue_cnt + 16'd1;
      if (skid_full) begin
        if (out_hs) begin
          out_q     <= skid_q;
          skid_full <= 1'b0;
          ready_q   <= 1'b1;
        end
      end else if (in_hs) begin
        if (!out_valid || out_ready) begin
          out_q     <= dec_op;
          out_valid <= 1'b1;
        end else begin
          skid_q    <= dec_op;
          skid_full <= 1'b1;
          ready_q   <= 1'b0;
        end
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end
`else
  // Plain pipeline register: accept whenever the output slot is free or leaving
  assign in_ready = !reset && (!out_valid || out_ready);

  // Output register; a simultaneous in/out handshake replaces it bubble-free
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      issue_cnt <= 16'd0;
    end else begin
      if (out_hs) issue_cnt <= issue_cnt + 16'd1;
      if (in_hs) begin
        out_q     <= dec_op;
        out_valid <= 1'b1;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Scoreboard bench for alu_issue_stage (works with or without ALU_ISSUE_SKID_EN).
module tb_alu_issue_stage;

  localparam int unsigned W = 32;
`ifdef ALU_ISSUE_SKID_EN
  localparam int EXP_EXTRA = 1;
`else
  localparam int EXP_EXTRA = 0;
`endif

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [1:0]    in_aluop;
  logic [5:0]    in_funct;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_a;
  logic [W-1:0]  out_b;
  logic          out_binv;
  logic          out_cin;
  logic          out_sel1;
  logic          out_sel0;
  logic          out_illegal;
  logic [15:0]   issue_cnt;

  int errors = 0;
  int checks = 0;
  int oh_cnt = 0;
  logic [71:0] sb[$];

  alu_issue_stage #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_aluop(in_aluop), .in_funct(in_funct),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b),
    .out_binv(out_binv), .out_cin(out_cin), .out_sel1(out_sel1), .out_sel0(out_sel0),
    .out_illegal(out_illegal), .issue_cnt(issue_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference decode: {pad, a, b, binv, cin, sel1, sel0, illegal}
  function automatic logic [71:0] model(input logic [1:0] op, input logic [5:0] fn,
                                        input logic [W-1:0] a, input logic [W-1:0] b);
    logic       binv;
    logic [1:0] sel;
    logic       ill;
    binv = 1'b0; sel = 2'b10; ill = 1'b0;
    case (op)
      2'b01: binv = 1'b1;
      2'b11: sel = 2'b01;
      2'b10: begin
        case (fn)
          6'h20: sel = 2'b10;
          6'h22: binv = 1'b1;
          6'h24: sel = 2'b00;
          6'h25: sel = 2'b01;
          6'h2A: begin binv = 1'b1; sel = 2'b11; end
          default: ill = 1'b1;
        endcase
      end
      default: sel = 2'b10;
    endcase
    return {3'b000, a, b, binv, binv, sel, ill};
  endfunction

  function automatic logic [71:0] actual();
    return {3'b000, out_a, out_b, out_binv, out_cin, out_sel1, out_sel0, out_illegal};
  endfunction

  // Monitor: pop/compare on output handshake, push on input handshake
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        oh_cnt++;
        check("sb_has_entry", 72'(sb.size() != 0), 72'(1));
        if (sb.size() != 0) check("sb_out", actual(), sb.pop_front());
      end
      if (in_valid && in_ready)
        sb.push_back(model(in_aluop, in_funct, in_a, in_b));
    end
  end

  task automatic tick(output bit hs);
    @(negedge clk);
    hs = in_valid && in_ready && !reset;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit hs;
    for (int i = 0; i < n; i++) tick(hs);
  endtask

  // Hold an op valid until accepted (bounded); returns cycles taken
  task automatic send(input logic [1:0] op, input logic [5:0] fn,
                      input logic [W-1:0] a, input logic [W-1:0] b, output int waited);
    bit hs;
    hs = 1'b0; waited = 0;
    in_valid = 1'b1; in_aluop = op; in_funct = fn; in_a = a; in_b = b;
    while (!hs && waited < 50) begin
      tick(hs);
      waited++;
    end
    check("send_accepted", 72'(hs), 72'(1));
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    idle(1);
    check("rst_in_ready", 72'(in_ready), 72'(0));
    idle(1);
    reset = 1'b0;
    in_valid = 1'b0;
    check("rst_out_valid", 72'(out_valid), 72'(0));
    check("rst_issue_cnt", 72'(issue_cnt), 72'(0));
    check("rst_out_word", actual(), 72'(0));
    oh_cnt = 0;
  endtask

  function automatic logic [5:0] fn_of(input int i);
    case (i % 5)
      0: return 6'h20;
      1: return 6'h22;
      2: return 6'h24;
      3: return 6'h25;
      default: return 6'h2A;
    endcase
  endfunction

  initial begin
    int w;
    int acc;
    bit hs;
    logic [71:0] held;

    reset = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_aluop = 2'b00; in_funct = 6'h00; out_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    // SLT decode, one-cycle latency
    out_ready = 1'b1;
    send(2'b10, 6'b101010, 32'd5, 32'd9, w);
    check("slt_valid", 72'(out_valid), 72'(1));
    check("slt_ctrl", 72'({out_binv, out_cin, out_sel1, out_sel0, out_illegal}), 72'(5'b11110));
    check("slt_a", 72'(out_a), 72'(5));
    check("slt_b", 72'(out_b), 72'(9));
    idle(1);

    // Undefined funct under ALUOp 10
    send(2'b10, 6'b000111, 32'd1, 32'd2, w);
    check("ill_ctrl", 72'({out_binv, out_cin, out_sel1, out_sel0, out_illegal}), 72'(5'b00101));
    idle(1);

    // Other ALUOp codes
    send(2'b00, 6'h3F, 32'h11, 32'h22, w);
    send(2'b01, 6'h00, 32'h33, 32'h44, w);
    send(2'b11, 6'h2A, 32'h55, 32'h66, w);
    idle(2);

    // Output stall for 4 cycles with ops arriving
    out_ready = 1'b0;
    send(2'b00, 6'h00, 32'd100, 32'd1, w);
    held = actual();
    acc = 0;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_aluop = 2'b01; in_funct = 6'h00; in_a = 32'd200 + 32'(acc); in_b = 32'd7;
      tick(hs);
      if (hs) acc++;
      check("stall_hold", actual(), held);
      check("stall_valid", 72'(out_valid), 72'(1));
    end
    check("stall_extra", 72'(acc), 72'(EXP_EXTRA));
    check("stall_in_ready", 72'(in_ready), 72'(0));
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(4);
    check("drain_empty", 72'(sb.size()), 72'(0));
    check("drain_valid", 72'(out_valid), 72'(0));

    // Back-to-back throughput: 20 ops, one per cycle
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      send(2'b10, fn_of(i), 32'(i * 3 + 1), 32'(i + 40), w);
      check("tput_wait", 72'(w), 72'(1));
      check("tput_out_valid", 72'(out_valid), 72'(1));
    end
    idle(1);
    check("tput_handshakes", 72'(oh_cnt), 72'(20));
    check("tput_issue_cnt", 72'(issue_cnt), 72'(20));

    // Counter wrap
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 65535; i++) send(2'b00, 6'h00, 32'(i), 32'd1, w);
    idle(1);
    check("wrap_ffff", 72'(issue_cnt), 72'(16'hFFFF));
    send(2'b11, 6'h00, 32'd9, 32'd9, w);
    idle(1);
    check("wrap_zero", 72'(issue_cnt), 72'(0));
    check("wrap_empty", 72'(sb.size()), 72'(0));

    // Reset with output full and skid occupied
    send(2'b00, 6'h00, 32'd1, 32'd1, w);
    idle(1);
    check("pre_rst_cnt", 72'(issue_cnt), 72'(1));
    out_ready = 1'b0;
    send(2'b01, 6'h00, 32'hAAA, 32'h1, w);
    in_valid = 1'b1; in_aluop = 2'b11; in_a = 32'hBBB; in_b = 32'h2;
    idle(2);
    check("pre_rst_valid", 72'(out_valid), 72'(1));
    check("pre_rst_in_ready", 72'(in_ready), 72'(0));
    reset = 1'b1;
    in_valid = 1'b0;
    idle(1);
    reset = 1'b0;
    check("post_rst_valid", 72'(out_valid), 72'(0));
    check("post_rst_cnt", 72'(issue_cnt), 72'(0));
    oh_cnt = 0;
    out_ready = 1'b1;
    idle(4);
    check("no_ghost", 72'(oh_cnt), 72'(0));
    check("no_ghost_valid", 72'(out_valid), 72'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
